// File: rtl/debug_instr_encoder.sv
// Turns abstract debug register-access commands into RV32IF instruction words
// and hands them, one per handshake, to the core's instruction-injection port.
module debug_instr_encoder #(
    parameter logic [11:0] DSCRATCH0 = 12'h7B2,
    parameter logic [11:0] DSCRATCH1 = 12'h7B3,
    parameter logic [4:0]  TEMP_REG  = 5'd8
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_write_i,
    input  logic [15:0] cmd_regno_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic        done_o,
    output logic        err_o
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ERR} state_t;
    typedef enum logic [1:0] {K_GPR, K_CSR, K_FPR, K_BAD} kind_t;

    state_t      state_q, state_d;
    kind_t       kind_q, kind_d;
    logic [1:0]  step_q, step_d;
    logic        write_q, write_d;
    logic [11:0] regno_q, regno_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    kind_t       kind_in;
    logic        accept;
    logic [1:0]  last_step;

    function automatic logic [31:0] csrw(input logic [11:0] csr, input logic [4:0] rs1);
        return {csr, rs1, 3'b001, 5'd0, 7'h73};
    endfunction

    function automatic logic [31:0] csrr(input logic [4:0] rd, input logic [11:0] csr);
        return {csr, 5'd0, 3'b010, rd, 7'h73};
    endfunction

    function automatic logic [31:0] fmvxw(input logic [4:0] rd, input logic [4:0] fs);
        return {7'b1110000, 5'd0, fs, 3'b000, rd, 7'h53};
    endfunction

    function automatic logic [31:0] fmvwx(input logic [4:0] fd, input logic [4:0] rs);
        return {7'b1111000, 5'd0, rs, 3'b000, fd, 7'h53};
    endfunction

    function automatic kind_t classify(input logic [15:0] regno);
        if (regno[15:12] == 4'h0)        return K_CSR;
        else if (regno[15:5] == 11'h080) return K_GPR;
        else if (regno[15:5] == 11'h081) return K_FPR;
        else                             return K_BAD;
    endfunction

    // CSR and FPR sequences share the save/restore of the temp GPR around
    // a single data move through dscratch0.
    function automatic logic [31:0] seq_word(input kind_t kind, input logic wr,
                                             input logic [11:0] c, input logic [1:0] step);
        logic [4:0] n;
        n = c[4:0];
        if (kind == K_GPR) begin
            return wr ? csrr(n, DSCRATCH0) : csrw(DSCRATCH0, n);
        end
        case (step)
            2'd0:    return csrw(DSCRATCH1, TEMP_REG);
            2'd1:    return wr ? csrr(TEMP_REG, DSCRATCH0)
                               : ((kind == K_CSR) ? csrr(TEMP_REG, c) : fmvxw(TEMP_REG, n));
            2'd2:    return wr ? ((kind == K_CSR) ? csrw(c, TEMP_REG) : fmvwx(n, TEMP_REG))
                               : csrw(DSCRATCH0, TEMP_REG);
            default: return csrr(TEMP_REG, DSCRATCH1);
        endcase
    endfunction

    assign kind_in       = classify(cmd_regno_i);
    assign cmd_ready_o   = (state_q != S_ISSUE);
    assign accept        = cmd_valid_i && cmd_ready_o;
    assign last_step     = (kind_q == K_GPR) ? 2'd0 : 2'd3;
    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign done_o        = done_q;
    assign err_o         = err_q;

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        step_d  = step_q;
        write_d = write_q;
        regno_d = regno_q;
        instr_d = instr_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_ISSUE: begin
                if (instr_ready_i) begin
                    if (step_q == last_step) begin
                        state_d = S_IDLE;
                        valid_d = 1'b0;
                        instr_d = 32'd0;
                        done_d  = 1'b1;
                    end else begin
                        step_d  = step_q + 2'd1;
                        instr_d = seq_word(kind_q, write_q, regno_q, step_q + 2'd1);
                    end
                end
            end
            default: begin
                // ERR behaves like IDLE for acceptance so a command can follow
                // immediately in the cycle its done/err pulse is visible.
                state_d = S_IDLE;
                if (accept) begin
                    kind_d  = kind_in;
                    write_d = cmd_write_i;
                    regno_d = cmd_regno_i[11:0];
                    step_d  = 2'd0;
                    if (kind_in == K_BAD) begin
                        state_d = S_ERR;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                        valid_d = 1'b1;
                        instr_d = seq_word(kind_in, cmd_write_i, cmd_regno_i[11:0], 2'd0);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            kind_q  <= K_GPR;
            step_q  <= 2'd0;
            write_q <= 1'b0;
            regno_q <= 12'd0;
            instr_q <= 32'd0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            step_q  <= step_d;
            write_q <= write_d;
            regno_q <= regno_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_debug_instr_encoder.sv
// Directed bench: stimulus pushes expected instruction words and completion
// records into queues; an independent monitor pops and checks them.
module tb_debug_instr_encoder;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_write_i;
    logic [15:0] cmd_regno_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic        done_o;
    logic        err_o;

    int total = 0;
    int bad   = 0;
    logic        mon_en = 1'b0;
    logic [31:0] instr_exp_q[$];
    logic        err_exp_q[$];

    always #5 clk_i = ~clk_i;

    debug_instr_encoder dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_write_i(cmd_write_i), .cmd_regno_i(cmd_regno_i),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
        .instr_o(instr_o), .done_o(done_o), .err_o(err_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every valid cycle must show the head of the expected queue
    // (this also covers holding stable under back-pressure).
    initial begin
        forever begin
            @(negedge clk_i);
            if (mon_en) begin
                if (instr_valid_o) begin
                    if (instr_exp_q.size() == 0) chk("unexpected_valid", instr_o, 32'hx);
                    else begin
                        chk("instr", instr_o, instr_exp_q[0]);
                        if (instr_ready_i) void'(instr_exp_q.pop_front());
                    end
                end
                if (done_o) begin
                    if (err_exp_q.size() == 0) chk("unexpected_done", {31'd0, err_o}, 32'hx);
                    else begin
                        chk("err_on_done", {31'd0, err_o}, {31'd0, err_exp_q.pop_front()});
                        chk("cmd_ready_on_done", {31'd0, cmd_ready_o}, 32'd1);
                    end
                end else if (err_o) begin
                    chk("err_without_done", {31'd0, err_o}, 32'd0);
                end
            end
        end
    end

    task automatic send(input string name, input logic wr, input logic [15:0] regno,
                        input int n, input logic [31:0] w0, input logic [31:0] w1,
                        input logic [31:0] w2, input logic [31:0] w3,
                        input logic exp_err, input int stall, input int exp_lat);
        logic [31:0] ws[4];
        int k;
        bit got;
        ws[0] = w0; ws[1] = w1; ws[2] = w2; ws[3] = w3;
        for (int i = 0; i < n; i++) instr_exp_q.push_back(ws[i]);
        err_exp_q.push_back(exp_err);
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_regno_i = regno;
        instr_ready_i = (stall == 0);
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0; cmd_write_i = ~wr; cmd_regno_i = 16'hFFFF;
        k = 1; got = 0;
        while (k <= 30 && !got) begin
            instr_ready_i = (k > stall);
            @(negedge clk_i);
            if (done_o) got = 1;
            else begin
                @(posedge clk_i); #1;
                k++;
            end
        end
        chk({name, "_done_latency"}, k, exp_lat);
        instr_ready_i = 1'b1;
        $display("txn %s write=%0d regno=%h latency=%0d", name, wr, regno, k);
    endtask

    initial begin
        reset_i = 1'b1; cmd_valid_i = 1'b0; cmd_write_i = 1'b0;
        cmd_regno_i = 16'd0; instr_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 reset_i = 1'b0;
        @(negedge clk_i);
        chk("rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
        chk("rst_instr_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("rst_instr", instr_o, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        mon_en = 1'b1;

        send("gpr_rd_x5", 1'b0, 16'h1005, 1, 32'h7B229073, 0, 0, 0, 1'b0, 0, 2);
        send("gpr_wr_x5_stall", 1'b1, 16'h1005, 1, 32'h7B2022F3, 0, 0, 0, 1'b0, 3, 5);
        send("csr_rd_300", 1'b0, 16'h0300, 4, 32'h7B341073, 32'h30002473,
             32'h7B241073, 32'h7B302473, 1'b0, 0, 5);
        send("fpr_rd_f3", 1'b0, 16'h1023, 4, 32'h7B341073, 32'hE0018453,
             32'h7B241073, 32'h7B302473, 1'b0, 0, 5);
        send("csr_wr_300", 1'b1, 16'h0300, 4, 32'h7B341073, 32'h7B202473,
             32'h30041073, 32'h7B302473, 1'b0, 0, 5);
        send("fpr_wr_f3_stall", 1'b1, 16'h1023, 4, 32'h7B341073, 32'h7B202473,
             32'hF00401D3, 32'h7B302473, 1'b0, 2, 7);
        send("bad_2000", 1'b0, 16'h2000, 0, 0, 0, 0, 0, 1'b1, 0, 1);
        send("bad_1040", 1'b1, 16'h1040, 0, 0, 0, 0, 0, 1'b1, 0, 1);
        send("gpr_wr_x0", 1'b1, 16'h1000, 1, 32'h7B202073, 0, 0, 0, 1'b0, 0, 2);
        send("csr_wr_fff", 1'b1, 16'h0FFF, 4, 32'h7B341073, 32'h7B202473,
             32'hFFF41073, 32'h7B302473, 1'b0, 0, 5);

        // Reset while step 2 of a CSR write is on the port.
        instr_exp_q.push_back(32'h7B341073);
        instr_exp_q.push_back(32'h7B202473);
        instr_exp_q.push_back(32'h30041073);
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_regno_i = 16'h0300;
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i); #1;
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        @(negedge clk_i);
        chk("abort_instr_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("abort_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
        chk("abort_done", {31'd0, done_o}, 32'd0);
        chk("abort_leftover_instrs", instr_exp_q.size(), 32'd0);
        $display("txn reset_abort csr_wr_300");
        repeat (2) @(negedge clk_i);

        send("gpr_rd_x31_after_rst", 1'b0, 16'h101F, 1, 32'h7B2F9073, 0, 0, 0, 1'b0, 0, 2);

        repeat (3) @(negedge clk_i);
        chk("instr_queue_empty", instr_exp_q.size(), 32'd0);
        chk("done_queue_empty", err_exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
